// File: rtl/dda_ray_tracer.sv
// dda_ray_tracer: start/done driven DDA grid walker for the raycaster.
//
// A trace is requested with i_start while o_busy is low. The player position,
// ray direction and per-axis step distances are latched. The tracer then
// walks the map one cell per two cycles (STEP moves, TEST reads i_map_val).
// It stops on a non-zero cell, at the map border, or when MAX_STEPS cells
// have been tested. It reports the hit flag, the side, the wall id and the
// saturated perpendicular distance.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   i_start                     trace request (ignored while o_busy)
//   i_playerX/Y                 signed Q(QM.QN) player position
//   i_rayDirX/Y                 signed Q(QM.QN) ray direction
//   i_stepDistX/Y               unsigned |1/rayDir|, saturated for zero dir
//   o_map_col/o_map_row         cell currently under test
//   i_map_val                   combinational map read of that cell
//   o_busy                      trace in progress
//   o_done                      one-cycle pulse; results held until next start
//   o_hit, o_side, o_wall_id    result flags / id
//   o_vdist                     Q(VD_INT.VD_FRAC) distance, all-ones on no hit
//   o_tex                       texture column
//
// Optional feature macro: DDA_TRACER_TEX_EN adds a TEX state (one extra cycle)
// and computes o_tex. Without it, o_tex is constant 0 and no multiplier is
// built for it.
module dda_ray_tracer #(
    parameter int QM        = 12,
    parameter int QN        = 12,
    parameter int MAP_BITS  = 4,
    parameter int MAP_VAL_W = 2,
    parameter int MAX_STEPS = 64,
    parameter int VD_INT    = 7,
    parameter int VD_FRAC   = 9,
    parameter int TEX_BITS  = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_start,
    input  logic signed [QM+QN-1:0]     i_playerX,
    input  logic signed [QM+QN-1:0]     i_playerY,
    input  logic signed [QM+QN-1:0]     i_rayDirX,
    input  logic signed [QM+QN-1:0]     i_rayDirY,
    input  logic [QM+QN-1:0]            i_stepDistX,
    input  logic [QM+QN-1:0]            i_stepDistY,
    output logic [MAP_BITS-1:0]         o_map_col,
    output logic [MAP_BITS-1:0]         o_map_row,
    input  logic [MAP_VAL_W-1:0]        i_map_val,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_hit,
    output logic                        o_side,
    output logic [MAP_VAL_W-1:0]        o_wall_id,
    output logic [VD_INT+VD_FRAC-1:0]   o_vdist,
    output logic [TEX_BITS-1:0]         o_tex
);
    localparam int W = QM + QN;
    localparam int VW = VD_INT + VD_FRAC;
    localparam logic [MAP_BITS-1:0] MAP_MAX = '1;
    localparam logic [W-1:0] TD_SAT = '1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_STEP, S_TEST, S_TEX, S_DONE} state_t;
    state_t state_reg, state_next;

    logic signed [W-1:0] px_reg, py_reg, dx_reg, dy_reg;
    logic [W-1:0]        sx_reg, sy_reg, tdx_reg, tdy_reg;
    logic [MAP_BITS-1:0] mx_reg, my_reg;
    logic [7:0]          steps_reg;
    logic                side_reg;

    // Zero direction counts as decreasing.
    logic rxi, ryi;
    assign rxi = !dx_reg[W-1] && (dx_reg != '0);
    assign ryi = !dy_reg[W-1] && (dy_reg != '0);

    // Initial distance to the first gridline on each axis.
    logic [QN:0]  part_x, part_y;
    logic [W+QN:0] prod_x, prod_y;
    assign part_x = rxi ? ({1'b1, {QN{1'b0}}} - {1'b0, px_reg[QN-1:0]}) : {1'b0, px_reg[QN-1:0]};
    assign part_y = ryi ? ({1'b1, {QN{1'b0}}} - {1'b0, py_reg[QN-1:0]}) : {1'b0, py_reg[QN-1:0]};
    assign prod_x = {{(QN+1){1'b0}}, sx_reg} * {{W{1'b0}}, part_x};
    assign prod_y = {{(QN+1){1'b0}}, sy_reg} * {{W{1'b0}}, part_y};

    // Step choice; a tie steps Y. Track accumulation saturates instead of wrapping.
    logic          need_x, edge_x, edge_y, edge_hit;
    logic [W:0]    sum_x, sum_y;
    logic [W-1:0]  tdx_sat, tdy_sat;
    assign need_x   = tdx_reg < tdy_reg;
    assign edge_x   = rxi ? (mx_reg == MAP_MAX) : (mx_reg == '0);
    assign edge_y   = ryi ? (my_reg == MAP_MAX) : (my_reg == '0);
    assign edge_hit = need_x ? edge_x : edge_y;
    assign sum_x    = {1'b0, tdx_reg} + {1'b0, sx_reg};
    assign sum_y    = {1'b0, tdy_reg} + {1'b0, sy_reg};
    assign tdx_sat  = sum_x[W] ? TD_SAT : sum_x[W-1:0];
    assign tdy_sat  = sum_y[W] ? TD_SAT : sum_y[W-1:0];

    // Perpendicular distance: track distance before the last step.
    logic [W-1:0]  vd;
    logic [VW-1:0] vd_sat;
    assign vd     = side_reg ? (tdy_reg - sy_reg) : (tdx_reg - sx_reg);
    assign vd_sat = (|vd[W-1:QN+VD_INT]) ? '1 : vd[QN+VD_INT-1:QN-VD_FRAC];

    logic                 fin_hit, side_now, enter_done;
    logic [MAP_VAL_W-1:0] fin_wall;

`ifdef DDA_TRACER_TEX_EN
    logic                 hit_reg;
    logic [MAP_VAL_W-1:0] wall_reg;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        fin_hit    = 1'b0;
        fin_wall   = '0;
        case (state_reg)
            S_IDLE: if (i_start) state_next = S_PREP;
            S_PREP: state_next = S_STEP;
            S_STEP: state_next = edge_hit ? S_DONE : S_TEST;
            S_TEST: begin
                if (i_map_val != '0) begin
                    fin_hit  = 1'b1;
                    fin_wall = i_map_val;
                end
                if (i_map_val != '0 || steps_reg == 8'(MAX_STEPS)) begin
`ifdef DDA_TRACER_TEX_EN
                    state_next = S_TEX;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_STEP;
                end
            end
            S_TEX: begin
`ifdef DDA_TRACER_TEX_EN
                fin_hit  = hit_reg;
                fin_wall = wall_reg;
`endif
                state_next = S_DONE;
            end
            S_DONE: state_next = i_start ? S_PREP : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    assign enter_done = (state_next == S_DONE) && (state_reg != S_DONE);
    assign side_now   = (state_reg == S_STEP) ? ~need_x : side_reg;
    assign o_busy     = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign o_map_col  = mx_reg;
    assign o_map_row  = my_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            px_reg    <= '0;
            py_reg    <= '0;
            dx_reg    <= '0;
            dy_reg    <= '0;
            sx_reg    <= '0;
            sy_reg    <= '0;
            tdx_reg   <= '0;
            tdy_reg   <= '0;
            mx_reg    <= '0;
            my_reg    <= '0;
            steps_reg <= '0;
            side_reg  <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        px_reg <= i_playerX;
                        py_reg <= i_playerY;
                        dx_reg <= i_rayDirX;
                        dy_reg <= i_rayDirY;
                        sx_reg <= i_stepDistX;
                        sy_reg <= i_stepDistY;
                    end
                end
                S_PREP: begin
                    mx_reg    <= px_reg[QN+MAP_BITS-1:QN];
                    my_reg    <= py_reg[QN+MAP_BITS-1:QN];
                    tdx_reg   <= prod_x[W+QN-1:QN];
                    tdy_reg   <= prod_y[W+QN-1:QN];
                    steps_reg <= '0;
                end
                S_STEP: begin
                    side_reg  <= ~need_x;
                    steps_reg <= steps_reg + 8'd1;
                    if (need_x && !edge_x) begin
                        mx_reg  <= rxi ? mx_reg + 1'b1 : mx_reg - 1'b1;
                        tdx_reg <= tdx_sat;
                    end else if (!need_x && !edge_y) begin
                        my_reg  <= ryi ? my_reg + 1'b1 : my_reg - 1'b1;
                        tdy_reg <= tdy_sat;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_done    <= 1'b0;
            o_hit     <= 1'b0;
            o_side    <= 1'b0;
            o_wall_id <= '0;
            o_vdist   <= '0;
        end else begin
            o_done <= enter_done;
            if (enter_done) begin
                o_hit     <= fin_hit;
                o_side    <= side_now;
                o_wall_id <= fin_wall;
                o_vdist   <= fin_hit ? vd_sat : '1;
            end
        end
    end

`ifdef DDA_TRACER_TEX_EN
    // Wall hit coordinate along the face: the other axis' position plus
    // vd times that axis' direction, keeping the middle W bits of the product.
    logic signed [2*W:0] tex_prod;
    logic [W-1:0]        wall_part;
    logic signed [W-1:0] tex_dir, tex_pos;
    assign tex_dir   = side_reg ? dx_reg : dy_reg;
    assign tex_pos   = side_reg ? px_reg : py_reg;
    assign tex_prod  = $signed({{W{1'b0}}, vd}) * $signed({{(W+1){tex_dir[W-1]}}, tex_dir});
    assign wall_part = tex_pos + tex_prod[W+QN-1:QN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_reg  <= 1'b0;
            wall_reg <= '0;
            o_tex    <= '0;
        end else begin
            if (state_reg == S_TEST) begin
                hit_reg  <= fin_hit;
                wall_reg <= fin_wall;
            end
            if (enter_done) o_tex <= fin_hit ? wall_part[QN-1:QN-TEX_BITS] : '0;
        end
    end

    logic unused_tex;
    assign unused_tex = ^{tex_prod, wall_part};
`else
    assign o_tex = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{px_reg, py_reg, prod_x, prod_y, vd};

endmodule

// File: tb/tb_dda_ray_tracer.sv
// Self-checking bench for dda_ray_tracer. Two instances share stimulus:
// one with MAX_STEPS=64 and one with MAX_STEPS=4. Each trace's expected
// results come from a straightforward DDA walk over an array map.
module tb_dda_ray_tracer;
`ifdef DDA_TRACER_TEX_EN
    localparam int TEX_LAT = 1;
`else
    localparam int TEX_LAT = 0;
`endif

    typedef struct {
        logic        hit;
        logic        side;
        logic        edge_stop;
        logic [1:0]  wall;
        logic [15:0] vdist;
        logic [5:0]  tex;
        int          done_cyc;
        int          col;
        int          row;
    } res_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic i_start = 1'b0;
    logic signed [23:0] px, py, dx, dy;
    logic [23:0] sx, sy;
    logic signed [23:0] lpx, lpy, ldx, ldy;
    logic [23:0] lsx, lsy;
    logic [1:0] map [16][16];

    logic [3:0]  col_a, row_a, col_b, row_b;
    logic [1:0]  val_a, val_b, wall_a, wall_b;
    logic        busy_a, done_a, hit_a, side_a, busy_b, done_b, hit_b, side_b;
    logic [15:0] vdist_a, vdist_b;
    logic [5:0]  tex_a, tex_b;

    int total = 0;
    int bad = 0;
    int seen_a, seen_b;

    assign val_a = map[row_a][col_a];
    assign val_b = map[row_b][col_b];

    always #5 clk = ~clk;

    dda_ray_tracer dut_a (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_playerX(px), .i_playerY(py), .i_rayDirX(dx), .i_rayDirY(dy),
        .i_stepDistX(sx), .i_stepDistY(sy),
        .o_map_col(col_a), .o_map_row(row_a), .i_map_val(val_a),
        .o_busy(busy_a), .o_done(done_a), .o_hit(hit_a), .o_side(side_a),
        .o_wall_id(wall_a), .o_vdist(vdist_a), .o_tex(tex_a)
    );

    dda_ray_tracer #(.MAX_STEPS(4)) dut_b (
        .clk(clk), .reset(reset), .i_start(i_start),
        .i_playerX(px), .i_playerY(py), .i_rayDirX(dx), .i_rayDirY(dy),
        .i_stepDistX(sx), .i_stepDistY(sy),
        .o_map_col(col_b), .o_map_row(row_b), .i_map_val(val_b),
        .o_busy(busy_b), .o_done(done_b), .o_hit(hit_b), .o_side(side_b),
        .o_wall_id(wall_b), .o_vdist(vdist_b), .o_tex(tex_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Plain DDA walk from the latched inputs.
    function automatic res_t model(input int budget);
        res_t r;
        longint tdx, tdy, vd, prod, wp;
        int mx, my, n;
        bit rx, ry, step_x;
        rx = (ldx > 0);
        ry = (ldy > 0);
        mx = int'(lpx[15:12]);
        my = int'(lpy[15:12]);
        tdx = (longint'(lsx) * (rx ? 4096 - int'(lpx[11:0]) : int'(lpx[11:0]))) >> 12;
        tdy = (longint'(lsy) * (ry ? 4096 - int'(lpy[11:0]) : int'(lpy[11:0]))) >> 12;
        n = 0;
        r.hit = 1'b0;
        r.side = 1'b0;
        r.edge_stop = 1'b0;
        forever begin
            step_x = tdx < tdy;
            r.side = !step_x;
            if (step_x) begin
                if (rx ? mx == 15 : mx == 0) begin r.edge_stop = 1'b1; break; end
                mx += rx ? 1 : -1;
                tdx += longint'(lsx);
                if (tdx > 64'hFFFFFF) tdx = 64'hFFFFFF;
            end else begin
                if (ry ? my == 15 : my == 0) begin r.edge_stop = 1'b1; break; end
                my += ry ? 1 : -1;
                tdy += longint'(lsy);
                if (tdy > 64'hFFFFFF) tdy = 64'hFFFFFF;
            end
            n++;
            if (map[my][mx] != 2'd0) begin r.hit = 1'b1; break; end
            if (n == budget) break;
        end
        r.col = mx;
        r.row = my;
        r.done_cyc = r.edge_stop ? 2 * (n + 1) + 1 : 2 * n + 2 + TEX_LAT;
        r.wall = r.hit ? map[my][mx] : 2'd0;
        vd = (r.side ? tdy - longint'(lsy) : tdx - longint'(lsx)) & 64'hFFFFFF;
        if (!r.hit || vd >= (64'd1 << 19)) r.vdist = 16'hFFFF;
        else r.vdist = 16'(vd >> 3);
        r.tex = 6'd0;
        if (TEX_LAT == 1 && r.hit) begin
            prod = vd * (r.side ? longint'(ldx) : longint'(ldy));
            wp = (r.side ? longint'(lpx) : longint'(lpy)) + ((prod >>> 12) & 64'hFFFFFF);
            r.tex = 6'((wp >> 6) & 63);
        end
        return r;
    endfunction

    function automatic logic [23:0] recip(input int m);
        if (m == 0 || (32'd1 << 24) / m > 32'hFFFFFF) return 24'hFFFFFF;
        return 24'((32'd1 << 24) / m);
    endfunction

    task automatic clear_map();
        foreach (map[r, c]) map[r][c] = 2'd0;
    endtask

    task automatic rand_map();
        bit border;
        border = 1'($urandom_range(0, 1));
        foreach (map[r, c]) begin
            if (border && (r == 0 || r == 15 || c == 0 || c == 15)) map[r][c] = 2'($urandom_range(1, 3));
            else if ($urandom_range(0, 99) < 12) map[r][c] = 2'($urandom_range(1, 3));
            else map[r][c] = 2'd0;
        end
    endtask

    task automatic rand_inputs();
        int mgx, mgy;
        mgx = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8192));
        mgy = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8192));
        px = 24'($urandom_range(0, 16 * 4096 - 1));
        py = 24'($urandom_range(0, 16 * 4096 - 1));
        dx = ($urandom_range(0, 1) == 1) ? -24'(mgx) : 24'(mgx);
        dy = ($urandom_range(0, 1) == 1) ? -24'(mgy) : 24'(mgy);
        sx = recip(mgx);
        sy = recip(mgy);
    endtask

    task automatic set_in(input logic [23:0] ipx, ipy, idx, idy, isx, isy);
        px = ipx; py = ipy; dx = idx; dy = idy; sx = isx; sy = isy;
    endtask

    task automatic check_res(input string tag, input res_t e, input int seen, input bit proto,
                             input logic hit, input logic side, input logic [1:0] wall,
                             input logic [15:0] vdist, input logic [5:0] tex,
                             input logic [3:0] col, input logic [3:0] row);
        chk({tag, " done_cycle"}, seen, e.done_cyc);
        chk({tag, " busy_done_protocol"}, proto, 1);
        chk({tag, " hit"}, hit, e.hit);
        chk({tag, " wall_id"}, wall, e.wall);
        chk({tag, " vdist"}, vdist, e.vdist);
        chk({tag, " tex"}, tex, e.tex);
        chk({tag, " map_col"}, col, e.col);
        chk({tag, " map_row"}, row, e.row);
        if (!e.edge_stop) chk({tag, " side"}, side, e.side);
    endtask

    // One trace on both instances; inputs are scrambled and i_start pulsed
    // mid-trace to confirm the latched values are the ones used.
    task automatic run_trace(input string tag);
        res_t ea, eb;
        int last;
        bit proto_a, proto_b;
        lpx = px; lpy = py; ldx = dx; ldy = dy; lsx = sx; lsy = sy;
        ea = model(64);
        eb = model(4);
        last = ((ea.done_cyc > eb.done_cyc) ? ea.done_cyc : eb.done_cyc) + 2;
        @(negedge clk);
        i_start = 1'b1;
        @(posedge clk);
        seen_a = -1; seen_b = -1; proto_a = 1'b1; proto_b = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            i_start = (cyc == 2);
            if (cyc == 2) rand_inputs();
            if (busy_a !== (cyc < ea.done_cyc) || done_a !== (cyc == ea.done_cyc)) proto_a = 1'b0;
            if (busy_b !== (cyc < eb.done_cyc) || done_b !== (cyc == eb.done_cyc)) proto_b = 1'b0;
            if (done_a === 1'b1 && seen_a < 0) seen_a = cyc;
            if (done_b === 1'b1 && seen_b < 0) seen_b = cyc;
        end
        i_start = 1'b0;
        check_res({tag, " a"}, ea, seen_a, proto_a, hit_a, side_a, wall_a, vdist_a, tex_a, col_a, row_a);
        check_res({tag, " b"}, eb, seen_b, proto_b, hit_b, side_b, wall_b, vdist_b, tex_b, col_b, row_b);
        $display("trace %s: a hit=%0d side=%0d wall=%0d vdist=%h done@%0d | b hit=%0d done@%0d",
                 tag, hit_a, side_a, wall_a, vdist_a, seen_a, hit_b, seen_b);
    endtask

    initial begin
        bit no_done;
        set_in(24'h0, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        clear_map();
        repeat (2) @(negedge clk);
        chk("reset_state_a", {busy_a, done_a, hit_a, side_a, wall_a, vdist_a, tex_a, col_a, row_a}, 0);
        chk("reset_state_b", {busy_b, done_b, hit_b, side_b, wall_b, vdist_b, tex_b, col_b, row_b}, 0);
        reset = 1'b0;

        // Wall 1 at col 5, ray +X.
        clear_map(); map[2][5] = 2'd1;
        set_in(24'h2800, 24'h2800, 24'h1000, 24'h0, 24'h1000, 24'hFFFFFF);
        run_trace("c1");
        chk("c1 spec_vdist", vdist_a, 16'h0500);
        chk("c1 spec_done", seen_a, 8 + TEX_LAT);
        chk("c1 spec_side", side_a, 0);
        chk("c1 spec_wall", wall_a, 1);
        chk("c1 spec_tex", tex_a, (TEX_LAT == 1) ? 32 : 0);

        // Reset in cycle 5 of a trace aborts it with no o_done.
        set_in(24'h2800, 24'h2800, 24'h1000, 24'h0, 24'h1000, 24'hFFFFFF);
        @(negedge clk); i_start = 1'b1;
        @(posedge clk);
        @(negedge clk); i_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("abort busy_before", busy_a, 1);
        reset = 1'b1;
        #1;
        chk("abort outputs_a", {busy_a, done_a, hit_a, side_a, wall_a, vdist_a, tex_a, col_a, row_a}, 0);
        chk("abort outputs_b", {busy_b, done_b, hit_b, side_b, wall_b, vdist_b, tex_b, col_b, row_b}, 0);
        @(negedge clk); reset = 1'b0;
        no_done = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done_a !== 1'b0 || done_b !== 1'b0 || busy_a !== 1'b0) no_done = 1'b0;
        end
        chk("abort no_done", no_done, 1);
        $display("trace abort: reset mid-trace, quiet=%0d", no_done);

        // Border wall 2 at row 0, ray -Y.
        clear_map(); map[0][2] = 2'd2;
        set_in(24'h2800, 24'h2800, 24'h0, -24'sh1000, 24'hFFFFFF, 24'h1000);
        run_trace("c2");
        chk("c2 spec_vdist", vdist_a, 16'h0300);
        chk("c2 spec_side", side_a, 1);
        chk("c2 spec_done", seen_a, 6 + TEX_LAT);

        // Empty map: edge stop at col 15; budget stop on the 4-step instance.
        clear_map();
        set_in(24'h2800, 24'h2800, 24'h1000, 24'h0, 24'h1000, 24'hFFFFFF);
        run_trace("c3");
        chk("c3 spec_done", seen_a, 29);
        chk("c3 spec_vdist", vdist_a, 16'hFFFF);
        chk("c3 spec_col", col_a, 15);

        // Wall at col 10: beyond the 4-step budget.
        clear_map(); map[2][10] = 2'd3;
        set_in(24'h2800, 24'h2800, 24'h1000, 24'h0, 24'h1000, 24'hFFFFFF);
        run_trace("c4");
        chk("c4 budget_hit", hit_b, 0);
        chk("c4 budget_done", seen_b, 10 + TEX_LAT);
        chk("c4 far_hit", hit_a, 1);

        // Diagonal with tied track distances: Y first, then X.
        clear_map(); map[3][3] = 2'd1;
        set_in(24'h2800, 24'h2800, 24'h1000, 24'h1000, 24'h16A1, 24'h16A1);
        run_trace("c5");
        chk("c5 spec_side", side_a, 0);
        chk("c5 spec_hit", hit_a, 1);

        for (int t = 0; t < 120; t++) begin
            rand_map();
            rand_inputs();
            run_trace($sformatf("r%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
